// File: rtl/uv_ups_pkg.sv
// -----------------------------------------------------------------------------
// uv_ups_pkg
// Shared types and constants for the horizontal 2x chroma upsampler.
//   uv_ups_state_t : row sequencing states of uv_upsampler
//   C0/C1/C2       : magnitudes of the symmetric 6-tap interpolation kernel
//                    (+C0, -C1, +C2, +C2, -C1, +C0), sum = 256
//   RND            : rounding offset applied before the >>> 8
//   ACC_W          : signed accumulator width (covers -26392..91928)
// -----------------------------------------------------------------------------
package uv_ups_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_RUN   = 2'd2,
      S_FLUSH = 2'd3
   } uv_ups_state_t;

   localparam int C0    = 21;
   localparam int C1    = 52;
   localparam int C2    = 159;
   localparam int RND   = 128;
   localparam int ACC_W = 18;

endpackage

// File: rtl/uv_ups_fir.sv
// -----------------------------------------------------------------------------
// uv_ups_fir
// Combinational 6-tap interpolation MAC with rounding and clamp to 0..255.
// Ports:
//   w0..w5  in  8  window samples U[k-2..k+3]
//   result  out 8  clamp((21*(w0+w5) - 52*(w1+w4) + 159*(w2+w3) + 128) >>> 8)
//   clipped out 1  high when the clamp changed the value (low or high)
// -----------------------------------------------------------------------------
module uv_ups_fir
   import uv_ups_pkg::*;
(
   input  logic [7:0] w0,
   input  logic [7:0] w1,
   input  logic [7:0] w2,
   input  logic [7:0] w3,
   input  logic [7:0] w4,
   input  logic [7:0] w5,
   output logic [7:0] result,
   output logic       clipped
);

   localparam logic signed [ACC_W-1:0] K0 = ACC_W'(C0);
   localparam logic signed [ACC_W-1:0] K1 = ACC_W'(C1);
   localparam logic signed [ACC_W-1:0] K2 = ACC_W'(C2);
   localparam logic signed [ACC_W-1:0] KR = ACC_W'(RND);
   localparam logic signed [ACC_W-1:0] MAX_U8 = ACC_W'(255);

   logic signed [ACC_W-1:0] s05;
   logic signed [ACC_W-1:0] s14;
   logic signed [ACC_W-1:0] s23;
   logic signed [ACC_W-1:0] acc;
   logic [8:0]              sat;

   // Returns {clipped, value}; the shift is arithmetic so negatives stay negative.
   function automatic logic [8:0] sat_u8(input logic signed [ACC_W-1:0] a);
      logic signed [ACC_W-1:0] q;
      q = a >>> 8;
      if (q[ACC_W-1]) begin
         return {1'b1, 8'd0};
      end else if (q > MAX_U8) begin
         return {1'b1, 8'd255};
      end else begin
         return {1'b0, q[7:0]};
      end
   endfunction

   always_comb begin
      // Pair symmetric taps first so only three multiplies are needed.
      s05 = ACC_W'($signed({1'b0, w0})) + ACC_W'($signed({1'b0, w5}));
      s14 = ACC_W'($signed({1'b0, w1})) + ACC_W'($signed({1'b0, w4}));
      s23 = ACC_W'($signed({1'b0, w2})) + ACC_W'($signed({1'b0, w3}));
      acc = (K0 * s05) - (K1 * s14) + (K2 * s23) + KR;
      sat = sat_u8(acc);
   end

   assign result  = sat[7:0];
   assign clipped = sat[8];

endmodule

// File: rtl/uv_upsampler.sv
// -----------------------------------------------------------------------------
// uv_upsampler
// Streaming horizontal 2x chroma upsampler. For each decimated input position k
// it emits the pair {U[k], U'[2k+1]}, where the odd sample is a 6-tap FIR over
// U[k-2..k+3] with edge samples replicated at both row ends.
// Parameter:
//   ROW_SAMPLES  decimated samples per row (4..1023)
// Ports:
//   clock      in  1  system clock
//   reset      in  1  synchronous, active-high reset
//   in_valid   in  1  input sample valid
//   in_ready   out 1  sample accepted this cycle when in_valid is also high
//   in_data    in  8  decimated chroma sample
//   out_valid  out 1  output pair valid
//   out_ready  in  1  consumer accepts the pair
//   out_even   out 8  pass-through sample U[k]
//   out_odd    out 8  interpolated sample
//   row_done   out 1  one-cycle pulse alongside the last pair of a row
//   clip_count out 16 saturating count of clamped FIR results
//                     (only when UV_UPS_CLIP_STATS_EN is defined)
// -----------------------------------------------------------------------------
module uv_upsampler
   import uv_ups_pkg::*;
#(
   parameter int ROW_SAMPLES = 160
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_even,
   output logic [7:0]  out_odd,
   output logic        row_done
`ifdef UV_UPS_CLIP_STATS_EN
   ,
   output logic [15:0] clip_count
`endif
);

   localparam int CNT_W = 10;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ROW_SAMPLES - 1);

   uv_ups_state_t    state_q, state_d;
   logic [7:0]       win_q [6];
   logic [7:0]       win_d [6];
   logic [1:0]       fill_cnt_q, fill_cnt_d;
   logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
   logic [1:0]       flush_cnt_q, flush_cnt_d;
   logic             out_valid_q, out_valid_d;
   logic [7:0]       out_even_q, out_even_d;
   logic [7:0]       out_odd_q, out_odd_d;
   logic             row_done_q, row_done_d;

   logic             load_ok;
   logic             in_accept;
   logic             do_load;
   logic             shift_en;
   logic [7:0]       shift_val;
   logic [7:0]       fir_result;
   logic             fir_clipped;

   // The FIR always sees the pre-shift window, i.e. the pair being loaded.
   uv_ups_fir u_fir (
      .w0      (win_q[0]),
      .w1      (win_q[1]),
      .w2      (win_q[2]),
      .w3      (win_q[3]),
      .w4      (win_q[4]),
      .w5      (win_q[5]),
      .result  (fir_result),
      .clipped (fir_clipped)
   );

   // A new pair may enter the output register when it is empty or draining.
   always_comb begin
      load_ok = ~out_valid_q | out_ready;
      unique case (state_q)
         S_IDLE, S_FILL: in_ready = 1'b1;
         S_RUN:          in_ready = load_ok;
         default:        in_ready = 1'b0;
      endcase
   end

   assign in_accept = in_valid & in_ready;

   always_comb begin
      state_d     = state_q;
      win_d       = win_q;
      fill_cnt_d  = fill_cnt_q;
      in_cnt_d    = in_cnt_q;
      flush_cnt_d = flush_cnt_q;
      row_done_d  = 1'b0;
      do_load     = 1'b0;
      shift_en    = 1'b0;
      shift_val   = in_data;

      unique case (state_q)
         S_IDLE: begin
            // U0 fills the whole window: left-edge replication.
            if (in_accept) begin
               for (int i = 0; i < 6; i++) win_d[i] = in_data;
               fill_cnt_d = 2'd0;
               in_cnt_d   = CNT_W'(1);
               state_d    = S_FILL;
            end
         end
         S_FILL: begin
            if (in_accept) begin
               shift_en   = 1'b1;
               fill_cnt_d = fill_cnt_q + 2'd1;
               in_cnt_d   = in_cnt_q + CNT_W'(1);
               if (fill_cnt_q == 2'd2) begin
                  // With 4 samples per row U3 is already the last sample.
                  flush_cnt_d = 2'd0;
                  state_d     = (ROW_SAMPLES == 4) ? S_FLUSH : S_RUN;
               end
            end
         end
         S_RUN: begin
            if (in_accept) begin
               do_load  = 1'b1;
               shift_en = 1'b1;
               in_cnt_d = in_cnt_q + CNT_W'(1);
               if (in_cnt_q == LAST_IDX) begin
                  flush_cnt_d = 2'd0;
                  state_d     = S_FLUSH;
               end
            end
         end
         S_FLUSH: begin
            // Re-shifting the last sample replicates the right edge.
            if (load_ok) begin
               do_load     = 1'b1;
               shift_en    = 1'b1;
               shift_val   = win_q[5];
               flush_cnt_d = flush_cnt_q + 2'd1;
               if (flush_cnt_q == 2'd3) begin
                  row_done_d = 1'b1;
                  state_d    = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (shift_en) begin
         for (int i = 0; i < 5; i++) win_d[i] = win_q[i+1];
         win_d[5] = shift_val;
      end

      if (do_load) begin
         out_valid_d = 1'b1;
         out_even_d  = win_q[2];
         out_odd_d   = fir_result;
      end else begin
         out_valid_d = out_valid_q & ~out_ready;
         out_even_d  = out_even_q;
         out_odd_d   = out_odd_q;
      end
   end

`ifdef UV_UPS_CLIP_STATS_EN
   logic [15:0] clip_count_q, clip_count_d;

   always_comb begin
      clip_count_d = clip_count_q;
      if (do_load && fir_clipped && (clip_count_q != 16'hFFFF)) begin
         clip_count_d = clip_count_q + 16'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) clip_count_q <= 16'd0;
      else       clip_count_q <= clip_count_d;
   end

   assign clip_count = clip_count_q;
`else
   // Clip flag only feeds the optional statistics counter.
   logic unused_clip;
   assign unused_clip = fir_clipped;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         win_q       <= '{default: 8'd0};
         fill_cnt_q  <= 2'd0;
         in_cnt_q    <= '0;
         flush_cnt_q <= 2'd0;
         out_valid_q <= 1'b0;
         out_even_q  <= 8'd0;
         out_odd_q   <= 8'd0;
         row_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         win_q       <= win_d;
         fill_cnt_q  <= fill_cnt_d;
         in_cnt_q    <= in_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         out_valid_q <= out_valid_d;
         out_even_q  <= out_even_d;
         out_odd_q   <= out_odd_d;
         row_done_q  <= row_done_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_even  = out_even_q;
   assign out_odd   = out_odd_q;
   assign row_done  = row_done_q;

endmodule

// File: tb/tb_uv_upsampler.sv
// -----------------------------------------------------------------------------
// tb_uv_upsampler
// Scoreboard bench for uv_upsampler (ROW_SAMPLES = 160). Expected pairs are
// produced by an integer reference of the interpolator when each row is queued
// and compared as pairs are accepted at the output. Honours
// UV_UPS_CLIP_STATS_EN for the optional clip counter.
// -----------------------------------------------------------------------------
module tb_uv_upsampler;

   localparam int N = 160;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_even;
   logic [7:0]  out_odd;
   logic        row_done;
`ifdef UV_UPS_CLIP_STATS_EN
   logic [15:0] clip_count;
`endif

   uv_upsampler #(.ROW_SAMPLES(N)) dut (
      .clock     (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_even  (out_even),
      .out_odd   (out_odd),
      .row_done  (row_done)
`ifdef UV_UPS_CLIP_STATS_EN
      ,
      .clip_count(clip_count)
`endif
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   int exp_even_q[$];
   int exp_odd_q[$];
   int exp_idx_q[$];
   int exp_clips = 0;

   logic [7:0] row_buf [N];
   int got_even [N];
   int got_odd  [N];

   int rows_fed   = 0;
   int rows_done  = 0;
   int pairs_seen = 0;
   bit rnd_ready  = 0;
   bit gap_en     = 0;

   task automatic chk(input string tag, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
      end
   endtask

   // Reference interpolator: replicate edges, apply the kernel, clamp.
   task automatic push_expected();
      int w [6];
      int acc, q, idx;
      bit clip;
      for (int k = 0; k < N; k++) begin
         for (int i = 0; i < 6; i++) begin
            idx = k - 2 + i;
            if (idx < 0) idx = 0;
            if (idx > N - 1) idx = N - 1;
            w[i] = int'(row_buf[idx]);
         end
         acc  = 21 * (w[0] + w[5]) - 52 * (w[1] + w[4]) + 159 * (w[2] + w[3]) + 128;
         clip = 1'b0;
         if (acc < 0) begin
            q = 0;
            clip = 1'b1;
         end else begin
            q = acc / 256;
            if (q > 255) begin
               q = 255;
               clip = 1'b1;
            end
         end
         if (clip) exp_clips++;
         exp_even_q.push_back(w[2]);
         exp_odd_q.push_back(q);
         exp_idx_q.push_back(k);
      end
   endtask

   task automatic send_row(input int nsamp);
      logic took;
      int   waited;
      for (int j = 0; j < nsamp; j++) begin
         if (gap_en && ($urandom_range(0, 3) == 0)) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
         end
         in_valid = 1'b1;
         in_data  = row_buf[j];
         took     = 1'b0;
         waited   = 0;
         while (!took) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            if (!took) begin
               waited++;
               if (waited > 2000) begin
                  chk("in_accept_timeout", waited, 0);
                  in_valid = 1'b0;
                  return;
               end
            end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int cyc;
      cyc = 0;
      while (((exp_even_q.size() != 0) || (rows_done < rows_fed)) && (cyc < 5000)) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      if (cyc >= 5000) chk("drain_timeout", cyc, 0);
   endtask

   task automatic run_row();
      push_expected();
      send_row(N);
      rows_fed++;
   endtask

   // Output ready: always asserted, or a fair coin when rnd_ready is set.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Output monitor / scoreboard.
   bit         prev_stall = 0;
   logic [7:0] prev_even;
   logic [7:0] prev_odd;
   int         m_k, m_e, m_o;

   always @(negedge clk) begin
      if (reset) begin
         prev_stall = 0;
      end else begin
         if ((rows_fed > rows_done) && !row_done)
            chk("in_ready_flush", int'(in_ready), 0);
         if (prev_stall) begin
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_even", int'(out_even), int'(prev_even));
            chk("hold_odd", int'(out_odd), int'(prev_odd));
         end
         if (row_done) begin
            rows_done++;
            if (exp_idx_q.size() == 0) chk("row_done_spurious", 1, 0);
            else                       chk("row_done_idx", exp_idx_q[0], N - 1);
         end
         if (out_valid && out_ready) begin
            if (exp_even_q.size() == 0) begin
               chk("extra_pair", 1, 0);
            end else begin
               m_k = exp_idx_q.pop_front();
               m_e = exp_even_q.pop_front();
               m_o = exp_odd_q.pop_front();
               chk("pair_even", int'(out_even), m_e);
               chk("pair_odd", int'(out_odd), m_o);
               got_even[m_k] = int'(out_even);
               got_odd[m_k]  = int'(out_odd);
               pairs_seen++;
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_even  = out_even;
         prev_odd   = out_odd;
      end
   end

   int p0;
`ifdef UV_UPS_CLIP_STATS_EN
   int cc_before;
`endif

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_even", int'(out_even), 0);
      chk("rst_out_odd", int'(out_odd), 0);
      chk("rst_row_done", int'(row_done), 0);
      chk("rst_in_ready", int'(in_ready), 1);
`ifdef UV_UPS_CLIP_STATS_EN
      chk("rst_clip_count", int'(clip_count), 0);
`endif
      @(posedge clk);
      #1;

      // Constant row: flat input interpolates to itself.
      for (int j = 0; j < N; j++) row_buf[j] = 8'd100;
      run_row();
      wait_drain();
      chk("const_pairs", pairs_seen, N);
      chk("const_row_done", rows_done, 1);
      chk("const_even_0", got_even[0], 100);
      chk("const_odd_0", got_odd[0], 100);
      chk("const_odd_last", got_odd[N-1], 100);

      // Pair 2 window (0,255,0,0,255,0) is strongly negative -> 0.
      for (int j = 0; j < N; j++) row_buf[j] = 8'd0;
      row_buf[1] = 8'd255;
      row_buf[4] = 8'd255;
      run_row();
      wait_drain();
      chk("clip_low_k2", got_odd[2], 0);
      chk("clip_low_even_k2", got_even[2], 0);

      // Pair 2 window (255,0,255,255,0,255): acc 91928 -> 359 -> 255.
      for (int j = 0; j < N; j++) row_buf[j] = 8'd255;
      row_buf[1] = 8'd0;
      row_buf[4] = 8'd0;
`ifdef UV_UPS_CLIP_STATS_EN
      cc_before = int'(clip_count);
`endif
      run_row();
      wait_drain();
      chk("clip_high_k2", got_odd[2], 255);
`ifdef UV_UPS_CLIP_STATS_EN
      chk("clip_cnt_incr", int'(clip_count > 16'(cc_before)), 1);
`endif

      // Step 0,0,0,255,...: k2 window (0,0,0,255,255,255) -> 32768>>8 = 128;
      // k0 window (0,0,0,0,0,255) -> (21*255+128)>>8 = 21; right edge all 255.
      for (int j = 0; j < N; j++) row_buf[j] = (j < 3) ? 8'd0 : 8'd255;
      run_row();
      wait_drain();
      chk("step_k2", got_odd[2], 128);
      chk("step_k0", got_odd[0], 21);
      chk("step_k0_even", got_even[0], 0);
      chk("step_last", got_odd[N-1], 255);
      chk("step_rows_done", rows_done, 4);
`ifdef UV_UPS_CLIP_STATS_EN
      chk("clip_cnt_directed", int'(clip_count), exp_clips);
`endif

      // Three back-to-back random rows with random back-pressure and gaps.
      rnd_ready = 1;
      gap_en    = 1;
      for (int r = 0; r < 3; r++) begin
         for (int j = 0; j < N; j++) row_buf[j] = 8'($urandom_range(0, 255));
         run_row();
      end
      wait_drain();
      chk("rand_pairs", pairs_seen, 7 * N);
      chk("rand_rows_done", rows_done, 7);

      // Abandon a row after 50 samples with a one-cycle reset.
      for (int j = 0; j < N; j++) row_buf[j] = 8'($urandom_range(0, 255));
      push_expected();
      send_row(50);
      reset = 1'b1;
      exp_even_q.delete();
      exp_odd_q.delete();
      exp_idx_q.delete();
      exp_clips = 0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("abort_out_valid", int'(out_valid), 0);
      chk("abort_in_ready", int'(in_ready), 1);
      chk("abort_out_odd", int'(out_odd), 0);
      chk("abort_row_done", int'(row_done), 0);
`ifdef UV_UPS_CLIP_STATS_EN
      chk("abort_clip_count", int'(clip_count), 0);
`endif
      @(posedge clk);
      #1;

      // Fresh full row after the abort.
      p0 = pairs_seen;
      for (int j = 0; j < N; j++) row_buf[j] = 8'($urandom_range(0, 255));
      run_row();
      wait_drain();
      chk("fresh_pairs", pairs_seen - p0, N);
      chk("fresh_rows_done", rows_done, 8);
`ifdef UV_UPS_CLIP_STATS_EN
      chk("clip_cnt_final", int'(clip_count), exp_clips);
`endif
      repeat (5) @(posedge clk);
      chk("no_stray_pairs", pairs_seen - p0, N);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
